// File: rtl/bcd_counter_scan_nled_7seg.sv
// N-digit BCD up/down counter with prescaled count tick and multiplexed active-low 7-segment scan output.
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module bcd_counter_scan_nled_7seg #(
    parameter int N_DIGITS = 4,
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   load_val,
    output logic [4*N_DIGITS-1:0]   bcd,
    output logic                    carry,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an
);

    localparam int BW = 4 * N_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]       presc_r;
    logic [SW-1:0]       slot_r;
    logic [IW-1:0]       idx_r;
    logic [BW-1:0]       bcd_r;
    logic                carry_r;
    logic [6:0]          seg_r;
    logic [N_DIGITS-1:0] an_r;

    logic                tick_s;
    logic [BW-1:0]       count_next_s;
    logic                ripple_s;
    logic                wrap_s;
    logic [BW-1:0]       load_sat_s;
    logic [3:0]          sel_digit_s;
    logic [N_DIGITS-1:0] an_next_s;
    logic [6:0]          seg_next_s;

    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        if (d > 4'd9) begin
            return 4'd9;
        end else begin
            return d;
        end
    endfunction

    // Active-low pattern written g..a, bit 0 drives segment a.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Count step strobe: last prescaler cycle while enabled.
    always_comb begin
        tick_s = 1'b0;
        if (en && (presc_r == PRESC_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Decimal ripple: each digit only moves while every lower digit wrapped.
    always_comb begin
        count_next_s = bcd_r;
        ripple_s     = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (ripple_s) begin
                if (up_down) begin
                    if (bcd_r[4*i +: 4] == 4'd9) begin
                        count_next_s[4*i +: 4] = 4'd0;
                    end else begin
                        count_next_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd1;
                        ripple_s = 1'b0;
                    end
                end else begin
                    if (bcd_r[4*i +: 4] == 4'd0) begin
                        count_next_s[4*i +: 4] = 4'd9;
                    end else begin
                        count_next_s[4*i +: 4] = bcd_r[4*i +: 4] - 4'd1;
                        ripple_s = 1'b0;
                    end
                end
            end else begin
                count_next_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
        wrap_s = ripple_s;
    end

    // Saturate out-of-range load nibbles to 9.
    always_comb begin
        load_sat_s = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            load_sat_s[4*i +: 4] = sat_digit(load_val[4*i +: 4]);
        end
    end

    // Select the scanned digit and build the one-hot active-low anode pattern.
    always_comb begin
        sel_digit_s = 4'd0;
        an_next_s   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_r == IW'(i)) begin
                sel_digit_s  = bcd_r[4*i +: 4];
                an_next_s[i] = 1'b0;
            end else begin
                an_next_s[i] = 1'b1;
            end
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] zero_from_s;
    logic                zero_acc_s;
    logic                blank_s;

    // zero_from_s[k]: digit k and every digit above it are zero.
    always_comb begin
        zero_from_s = '0;
        zero_acc_s  = 1'b1;
        blank_s     = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_acc_s     = zero_acc_s & (bcd_r[4*i +: 4] == 4'd0);
            zero_from_s[i] = zero_acc_s;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if ((i != 0) && (idx_r == IW'(i)) && zero_from_s[i]) begin
                blank_s = 1'b1;
            end else begin
                blank_s = blank_s;
            end
        end
    end

    // Segment pattern with leading-zero blanking.
    always_comb begin
        seg_next_s = 7'b1111111;
        if (blank_s) begin
            seg_next_s = 7'b1111111;
        end else begin
            seg_next_s = seg_decode(sel_digit_s);
        end
    end
`else
    // Segment pattern, every digit displayed.
    always_comb begin
        seg_next_s = seg_decode(sel_digit_s);
    end
`endif

    // Prescaler: cleared by load, frozen while disabled.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            presc_r <= '0;
        end else if (load) begin
            presc_r <= '0;
        end else if (en) begin
            presc_r <= tick_s ? '0 : presc_r + PW'(1);
        end else begin
            presc_r <= presc_r;
        end
    end

    // Counter and wrap pulse; load takes precedence over a coincident tick.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            bcd_r   <= '0;
            carry_r <= 1'b0;
        end else if (load) begin
            bcd_r   <= load_sat_s;
            carry_r <= 1'b0;
        end else if (tick_s) begin
            bcd_r   <= count_next_s;
            carry_r <= wrap_s;
        end else begin
            bcd_r   <= bcd_r;
            carry_r <= 1'b0;
        end
    end

    // Free-running scan slot timer and digit index.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            slot_r <= '0;
            idx_r  <= '0;
        end else if (slot_r == SLOT_LAST) begin
            slot_r <= '0;
            idx_r  <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
        end else begin
            slot_r <= slot_r + SW'(1);
            idx_r  <= idx_r;
        end
    end

    // Registered display outputs, one cycle behind idx and bcd.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            seg_r <= 7'b1111111;
            an_r  <= '1;
        end else begin
            seg_r <= seg_next_s;
            an_r  <= an_next_s;
        end
    end

    assign bcd   = bcd_r;
    assign carry = carry_r;
    assign seg   = seg_r;
    assign an    = an_r;

endmodule
